cache_l1_controller: RTL
========================

Name: cache_l1_controller

Overview:
- Private per-core L1 data cache controller.
- Sits directly upstream of the shared directory-based L2: one instance per core (C0, C1).
- Serves processor loads/stores from a small direct-mapped MSI cache.
- On misses, write-upgrades and dirty evictions, issues bypass requests to L2 and waits for the fetch reply.
- Applies directory snoop messages (invalidate/fetch) to its lines.

Parameters:
- NUM_LINES, 4, number of direct-mapped lines (power of two); index = address[log2(NUM_LINES)-1:0], tag = remaining upper bits.
- ADDR_WIDTH, 8, byte address width.
- DATA_WIDTH, 8, data word width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpuReqValid  in  1  processor request valid
- cpuReqReady  out  1  controller can accept request
- cpuOp  in  1  0=read, 1=write
- cpuAddress  in  ADDR_WIDTH  request address
- cpuWriteData  in  DATA_WIDTH  store data
- cpuRespValid  out  1  one-cycle response pulse
- cpuReadData  out  DATA_WIDTH  response data (load value, or stored value for writes)
- bypassValid  out  1  request to L2 pending
- addressBypass  out  ADDR_WIDTH  request/writeback address
- operationBypass  out  1  0=read miss, 1=write miss/upgrade/writeback
- dataBypass  out  DATA_WIDTH  store or writeback data
- dataWriteBack  out  1  1 = current request is a dirty eviction
- fetchPresent  in  1  L2 completion pulse for current bypass request
- fetchData  in  DATA_WIDTH  fill data, valid with fetchPresent
- interconnectionMessage  in  3  snoop: 000 none, 001 INV, 010 FETCH, 011 FETCH_INV, 1xx ignored
- snoopAddress  in  ADDR_WIDTH  snoop target address
- snoopDataValid  out  1  one-cycle pulse: dirty data supplied
- snoopData  out  DATA_WIDTH  supplied dirty data

Behaviour:
- Line state encoding (2 bits): 00 Invalid, 10 Shared, 11 Modified. 01 is never written.
- Reset: all lines Invalid; tag and data arrays cleared to 0; FSM to IDLE. All outputs 0, except cpuReqReady, which is 1 from the first cycle after reset deasserts. Reset asserted mid-transaction abandons it: bypassValid drops on the next edge and no response is issued.
- FSM states: IDLE, LOOKUP, WRITEBACK, MISS_REQ, RESPOND.
- IDLE: cpuReqReady=1. On cpuReqValid&&cpuReqReady, capture op/address/wdata and go to LOOKUP. cpuReqReady=0 in every other state.
- LOOKUP, one cycle; hit = tag match && state!=Invalid.
  - Read hit → RESPOND.
  - Write hit in Modified → write data → RESPOND.
  - Write hit in Shared → MISS_REQ (upgrade, operationBypass=1).
  - Miss with victim Modified → WRITEBACK.
  - Miss otherwise → MISS_REQ.
- WRITEBACK: bypassValid=1, dataWriteBack=1, operationBypass=1, addressBypass={victim tag,index}, dataBypass=victim data. Held stable until fetchPresent, then victim→Invalid and go to MISS_REQ.
- MISS_REQ: bypassValid=1, dataWriteBack=0, addressBypass=captured address, operationBypass=captured op, dataBypass=captured wdata (0 for reads). Held stable until fetchPresent. On fetchPresent:
  - install tag;
  - data = wdata (write) or fetchData (read);
  - state = Modified (write) or Shared (read);
  - go to RESPOND.
- RESPOND: cpuRespValid=1 for exactly one cycle with the line data, then IDLE.
- Latency: hit response pulse 2 cycles after acceptance. Miss response pulse 1 cycle after fetchPresent.
- fetchPresent outside WRITEBACK/MISS_REQ is ignored.
- Snoops: evaluated every cycle in every state; act only when snoopAddress tag matches and the line is not Invalid.
  - INV → Invalid.
  - FETCH: if Modified, pulse snoopDataValid next cycle with the line data, then → Shared. A Shared line is unchanged.
  - FETCH_INV: if Modified, supply data; then → Invalid.
  - Snoop miss or 1xx: no effect, no pulse.
- Snoop hazards:
  - A snoop hitting the LOOKUP index in the LOOKUP cycle: snoop applied, LOOKUP repeats next cycle.
  - Snoop and fill to the same index in the same cycle: snoop applied to the old line first (data supplied if Modified), then the fill overwrites.
  - Snoop hitting the WRITEBACK victim: data supplied, line → Invalid. The writeback still completes.
- Index wrap: addresses differing only in tag alias the same line; always evict, never merge.

Test Plan:
- Reset, then read 0x05: MISS_REQ addressBypass=0x05, operationBypass=0. Reply fetchPresent with fetchData=0x3C → cpuRespValid pulse with 0x3C, line 1 = Shared. Re-read 0x05 → response 2 cycles after accept, no bypassValid.
- Write 0x05 data 0xA1 while line is Shared: upgrade request operationBypass=1, dataBypass=0xA1. After fetchPresent, line = Modified and response=0xA1.
- With 0x05 Modified (0xA1), read 0x09 (same index): WRITEBACK addressBypass=0x05, dataBypass=0xA1, dataWriteBack=1. Then MISS_REQ 0x09; fill 0x77 → response 0x77.
- Snoop FETCH 0x05 on Modified line 0xA1: snoopDataValid pulse with 0xA1 next cycle, line → Shared. Snoop INV 0x05 → Invalid; next read 0x05 misses.
- Snoop FETCH_INV to line index 1 with snoopAddress 0x05 while LOOKUP of 0x05 is in progress: LOOKUP repeats and the request becomes a miss. Snoop 0x0D (tag mismatch) → no change.
- Assert reset during MISS_REQ: bypassValid=0 next cycle, no cpuRespValid, all lines Invalid, cpuReqReady=1 after release.

Source files
------------

// File: rtl/cache_l1_controller.sv
// Private L1 data cache controller: direct-mapped MSI lines, bypass requests to the shared L2,
// and snoop handling for directory invalidate/fetch messages.
module cache_l1_controller #(
   parameter int unsigned NUM_LINES  = 4,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpuReqValid,
   output logic                  cpuReqReady,
   input  logic                  cpuOp,
   input  logic [ADDR_WIDTH-1:0] cpuAddress,
   input  logic [DATA_WIDTH-1:0] cpuWriteData,
   output logic                  cpuRespValid,
   output logic [DATA_WIDTH-1:0] cpuReadData,
   output logic                  bypassValid,
   output logic [ADDR_WIDTH-1:0] addressBypass,
   output logic                  operationBypass,
   output logic [DATA_WIDTH-1:0] dataBypass,
   output logic                  dataWriteBack,
   input  logic                  fetchPresent,
   input  logic [DATA_WIDTH-1:0] fetchData,
   input  logic [2:0]            interconnectionMessage,
   input  logic [ADDR_WIDTH-1:0] snoopAddress,
   output logic                  snoopDataValid,
   output logic [DATA_WIDTH-1:0] snoopData
);

   localparam int unsigned IdxW = $clog2(NUM_LINES);
   localparam int unsigned TagW = ADDR_WIDTH - IdxW;

   localparam logic [1:0] LineInvalid  = 2'b00;
   localparam logic [1:0] LineShared   = 2'b10;
   localparam logic [1:0] LineModified = 2'b11;

   typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StMissReq, StRespond} ctrlState_e;

   ctrlState_e stateQ, stateD;

   logic [1:0]            lineState [NUM_LINES];
   logic [TagW-1:0]       lineTag   [NUM_LINES];
   logic [DATA_WIDTH-1:0] lineData  [NUM_LINES];

   logic                  reqOp;
   logic [ADDR_WIDTH-1:0] reqAddress;
   logic [DATA_WIDTH-1:0] reqData;
   logic                  snoopValidQ;
   logic [DATA_WIDTH-1:0] snoopDataQ;

   logic [IdxW-1:0] reqIndex, snoopIndex;
   logic [TagW-1:0] reqTag, snoopTag;
   logic            hit, snoopHit, snoopSupply, snoopOnLookup, lookupWrite;

   assign reqIndex   = reqAddress[IdxW-1:0];
   assign reqTag     = reqAddress[ADDR_WIDTH-1:IdxW];
   assign snoopIndex = snoopAddress[IdxW-1:0];
   assign snoopTag   = snoopAddress[ADDR_WIDTH-1:IdxW];

   assign hit = (lineTag[reqIndex] == reqTag) && (lineState[reqIndex] != LineInvalid);

   // Only INV, FETCH and FETCH_INV act; 000 and 1xx are ignored.
   assign snoopHit = (interconnectionMessage == 3'b001 || interconnectionMessage == 3'b010 ||
                      interconnectionMessage == 3'b011) &&
                     (lineTag[snoopIndex] == snoopTag) && (lineState[snoopIndex] != LineInvalid);
   assign snoopSupply = snoopHit && interconnectionMessage[1] &&
                        (lineState[snoopIndex] == LineModified);

   assign snoopOnLookup = (stateQ == StLookup) && snoopHit && (snoopIndex == reqIndex);
   assign lookupWrite   = (stateQ == StLookup) && !snoopOnLookup && hit && reqOp &&
                          (lineState[reqIndex] == LineModified);

   assign snoopDataValid = snoopValidQ;
   assign snoopData      = snoopDataQ;

   always_comb begin
      stateD          = stateQ;
      cpuReqReady     = 1'b0;
      cpuRespValid    = 1'b0;
      cpuReadData     = '0;
      bypassValid     = 1'b0;
      addressBypass   = '0;
      operationBypass = 1'b0;
      dataBypass      = '0;
      dataWriteBack   = 1'b0;
      unique case (stateQ)
         StIdle: begin
            cpuReqReady = !reset;
            if (cpuReqValid && !reset) stateD = StLookup;
         end
         StLookup: begin
            // A snoop landing on the looked-up line changes its state, so look again.
            if (!snoopOnLookup) begin
               if (hit && !(reqOp && lineState[reqIndex] == LineShared)) begin
                  stateD = StRespond;
               end else if (!hit && lineState[reqIndex] == LineModified) begin
                  stateD = StWriteback;
               end else begin
                  stateD = StMissReq;
               end
            end
         end
         StWriteback: begin
            bypassValid     = 1'b1;
            dataWriteBack   = 1'b1;
            operationBypass = 1'b1;
            addressBypass   = {lineTag[reqIndex], reqIndex};
            dataBypass      = lineData[reqIndex];
            if (fetchPresent) stateD = StMissReq;
         end
         StMissReq: begin
            bypassValid     = 1'b1;
            operationBypass = reqOp;
            addressBypass   = reqAddress;
            dataBypass      = reqOp ? reqData : '0;
            if (fetchPresent) stateD = StRespond;
         end
         StRespond: begin
            cpuRespValid = 1'b1;
            cpuReadData  = lineData[reqIndex];
            stateD       = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ      <= StIdle;
         reqOp       <= 1'b0;
         reqAddress  <= '0;
         reqData     <= '0;
         snoopValidQ <= 1'b0;
         snoopDataQ  <= '0;
         for (int unsigned i = 0; i < NUM_LINES; i++) begin
            lineState[i] <= LineInvalid;
            lineTag[i]   <= '0;
            lineData[i]  <= '0;
         end
      end else begin
         stateQ <= stateD;
         if (stateQ == StIdle && cpuReqValid) begin
            reqOp      <= cpuOp;
            reqAddress <= cpuAddress;
            reqData    <= cpuWriteData;
         end
         snoopValidQ <= snoopSupply;
         snoopDataQ  <= snoopSupply ? lineData[snoopIndex] : '0;
         if (snoopHit) begin
            if (stateQ == StWriteback && snoopIndex == reqIndex) begin
               lineState[snoopIndex] <= LineInvalid;
            end else if (interconnectionMessage == 3'b010) begin
               if (lineState[snoopIndex] == LineModified) lineState[snoopIndex] <= LineShared;
            end else begin
               lineState[snoopIndex] <= LineInvalid;
            end
         end
         if (lookupWrite) lineData[reqIndex] <= reqData;
         if (stateQ == StWriteback && fetchPresent) lineState[reqIndex] <= LineInvalid;
         // Fill is written after the snoop update so it overwrites the old line.
         if (stateQ == StMissReq && fetchPresent) begin
            lineTag[reqIndex]   <= reqTag;
            lineData[reqIndex]  <= reqOp ? reqData : fetchData;
            lineState[reqIndex] <= reqOp ? LineModified : LineShared;
         end
      end
   end

endmodule
